// File: rtl/lsu_pkg.sv
// Shared types and helpers for the writeback-stage load/store unit.
//   lsu_state_t   : FSM state encoding
//   SZ_*          : MemSizeW encodings (2'b11 behaves as a word)
//   lsu_gen_be    : byte enables from size and address low bits
//   lsu_rep_wdata : store data replicated across byte lanes
//   lsu_misalign  : alignment check for an access
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic logic [3:0] lsu_gen_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: lsu_gen_be = 4'b0001 << lo;
      SZ_HALF: lsu_gen_be = 4'b0011 << lo;
      default: lsu_gen_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lsu_rep_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: lsu_rep_wdata = {4{data[7:0]}};
      SZ_HALF: lsu_rep_wdata = {2{data[15:0]}};
      default: lsu_rep_wdata = data;
    endcase
  endfunction

  function automatic logic lsu_misalign(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: lsu_misalign = 1'b0;
      SZ_HALF: lsu_misalign = lo[0];
      default: lsu_misalign = |lo;
    endcase
  endfunction

endpackage

// File: rtl/dp_load_align.sv
// Combinational load-data alignment and extension.
//   i_rdata    : raw 32-bit word from memory
//   i_addr_lo  : address bits [1:0] of the access
//   i_size     : access size (SZ_*), 2'b11 treated as word
//   i_unsigned : zero-extend instead of sign-extend
//   o_data     : aligned, extended result
module dp_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_size)
      SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/dp_wb_lsu.sv
// Writeback-stage load/store unit: runs one req/ack transaction on the
// data-memory bus per W-stage memory op, stalling W until the bus responds,
// then returns aligned/extended load data for register-file writeback.
//   clk, reset            : clock, synchronous active-low reset
//   MemReadW/MemWriteW    : W instruction is a load / store
//   MemSizeW, MemUnsignedW: access size and load zero-extend
//   FlushW                : hazard-unit flush of the W instruction
//   A3_W, ALUResultW, RD2_W : dest reg, address, store data
//   dmem_*                : external memory bus
//   StallW                : freeze W and upstream
//   LoadValidW/DataW/RdW  : one-cycle load writeback
//   MisalignW             : one-cycle misaligned-access pulse
//
// state | meaning
// IDLE  | waiting for a W-stage memory op
// BUSY  | request on the bus, waiting for dmem_ack
// DONE  | transaction finished, W advances, load writes back
module dp_wb_lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadW,
  input  logic        MemWriteW,
  input  logic [1:0]  MemSizeW,
  input  logic        MemUnsignedW,
  input  logic        FlushW,
  input  logic [4:0]  A3_W,
  input  logic [31:0] ALUResultW,
  input  logic [31:0] RD2_W,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  output logic        StallW,
  output logic        LoadValidW,
  output logic [31:0] LoadDataW,
  output logic [4:0]  LoadRdW,
  output logic        MisalignW
);

  lsu_state_t  r_state;
  logic        r_we;
  logic        r_unsigned;
  logic        r_cancel;
  logic [1:0]  r_size;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [4:0]  r_rd;
  logic [31:0] r_load_data;

  logic        w_idle_op;
  logic        w_misalign;
  logic        w_start;
  logic [31:0] w_align_data;

  // A new op is only considered while not in reset, so nothing starts in
  // the same cycle the FSM is being forced back to IDLE.
  assign w_idle_op  = reset & (r_state == ST_IDLE) & (MemReadW | MemWriteW) & ~FlushW;
  assign w_misalign = lsu_misalign(MemSizeW, ALUResultW[1:0]);
  assign w_start    = w_idle_op & ~w_misalign;

  assign MisalignW  = w_idle_op & w_misalign;
  assign StallW     = w_start | (r_state == ST_BUSY);
  assign dmem_req   = (r_state == ST_BUSY);
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_be    = r_be;
  assign dmem_wdata = r_wdata;

  // A flush arriving in DONE itself also kills the writeback.
  assign LoadValidW = (r_state == ST_DONE) & ~r_we & ~r_cancel & ~FlushW;
  assign LoadDataW  = r_load_data;
  assign LoadRdW    = r_rd;

  dp_load_align u_align (
    .i_rdata    (dmem_rdata),
    .i_addr_lo  (r_addr_lo),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_align_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_unsigned  <= 1'b0;
      r_cancel    <= 1'b0;
      r_size      <= 2'b00;
      r_addr_lo   <= 2'b00;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_be        <= 4'h0;
      r_rd        <= 5'h0;
      r_load_data <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cancel <= 1'b0;
          if (w_start) begin
            r_state    <= ST_BUSY;
            r_we       <= MemWriteW;
            r_unsigned <= MemUnsignedW;
            r_size     <= MemSizeW;
            r_addr_lo  <= ALUResultW[1:0];
            r_addr     <= {ALUResultW[31:2], 2'b00};
            r_wdata    <= lsu_rep_wdata(MemSizeW, RD2_W);
            r_be       <= lsu_gen_be(MemSizeW, ALUResultW[1:0]);
            r_rd       <= A3_W;
          end
        end
        ST_BUSY: begin
          // The bus transaction always completes; a flush only marks it dead.
          if (FlushW) r_cancel <= 1'b1;
          if (dmem_ack) begin
            if (!r_we) r_load_data <= w_align_data;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dp_wb_lsu.sv
module tb_dp_wb_lsu;

  logic        clk;
  logic        reset;
  logic        MemReadW;
  logic        MemWriteW;
  logic [1:0]  MemSizeW;
  logic        MemUnsignedW;
  logic        FlushW;
  logic [4:0]  A3_W;
  logic [31:0] ALUResultW;
  logic [31:0] RD2_W;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        StallW;
  logic        LoadValidW;
  logic [31:0] LoadDataW;
  logic [4:0]  LoadRdW;
  logic        MisalignW;

  int n_cmp = 0;
  int n_err = 0;

  dp_wb_lsu dut (
    .clk          (clk),
    .reset        (reset),
    .MemReadW     (MemReadW),
    .MemWriteW    (MemWriteW),
    .MemSizeW     (MemSizeW),
    .MemUnsignedW (MemUnsignedW),
    .FlushW       (FlushW),
    .A3_W         (A3_W),
    .ALUResultW   (ALUResultW),
    .RD2_W        (RD2_W),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .StallW       (StallW),
    .LoadValidW   (LoadValidW),
    .LoadDataW    (LoadDataW),
    .LoadRdW      (LoadRdW),
    .MisalignW    (MisalignW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemReadW     = 1'b0;
    MemWriteW    = 1'b0;
    MemSizeW     = 2'b00;
    MemUnsignedW = 1'b0;
    FlushW       = 1'b0;
    A3_W         = 5'd0;
    ALUResultW   = 32'h0;
    RD2_W        = 32'h0;
    dmem_ack     = 1'b0;
    dmem_rdata   = 32'h0;
  endtask

  // One aligned memory op; the bench plays the memory, acking after 'waits'
  // extra BUSY cycles. Outputs are sampled mid-cycle (#4 after the drive).
  task automatic do_op(input string tag, input logic rd, input logic wr,
                       input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] a3, input int waits,
                       input logic [31:0] rdata, input logic flush_busy,
                       input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                       input logic exp_valid, input logic [31:0] exp_data);
    int n_stall;
    int n_req;
    n_stall = 0;
    n_req   = 0;
    MemReadW = rd; MemWriteW = wr; MemSizeW = sz; MemUnsignedW = uns;
    ALUResultW = addr; RD2_W = wd; A3_W = a3; FlushW = 1'b0; dmem_ack = 1'b0;
    #4;
    n_stall += int'(StallW); n_req += int'(dmem_req);
    chk_eq({tag, " idle stall"}, {31'd0, StallW}, 32'd1);
    step();
    for (int i = 0; i <= waits; i++) begin
      dmem_ack   = (i == waits);
      dmem_rdata = (i == waits) ? rdata : 32'h5A5A5A5A;
      FlushW     = flush_busy;
      #4;
      n_stall += int'(StallW); n_req += int'(dmem_req);
      if (i == 0) begin
        chk_eq({tag, " addr"},  dmem_addr, {addr[31:2], 2'b00});
        chk_eq({tag, " be"},    {28'd0, dmem_be}, {28'd0, exp_be});
        chk_eq({tag, " we"},    {31'd0, dmem_we}, {31'd0, wr});
        if (wr) chk_eq({tag, " wdata"}, dmem_wdata, exp_wdata);
      end
      step();
    end
    dmem_ack = 1'b0; dmem_rdata = 32'h0; FlushW = 1'b0;
    #4;
    n_stall += int'(StallW); n_req += int'(dmem_req);
    chk_eq({tag, " done valid"}, {31'd0, LoadValidW}, {31'd0, exp_valid});
    if (exp_valid) begin
      chk_eq({tag, " data"}, LoadDataW, exp_data);
      chk_eq({tag, " rd"},   {27'd0, LoadRdW}, {27'd0, a3});
    end
    step();
    MemReadW = 1'b0; MemWriteW = 1'b0;
    #4;
    n_stall += int'(StallW); n_req += int'(dmem_req);
    chk_eq({tag, " after valid"}, {31'd0, LoadValidW}, 32'd0);
    chk_eq({tag, " stall cycles"}, n_stall, waits + 2);
    chk_eq({tag, " req cycles"},   n_req,   waits + 1);
    step();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    #4;
    chk_eq("rst req",   {31'd0, dmem_req},   32'd0);
    chk_eq("rst we",    {31'd0, dmem_we},    32'd0);
    chk_eq("rst stall", {31'd0, StallW},     32'd0);
    chk_eq("rst valid", {31'd0, LoadValidW}, 32'd0);
    chk_eq("rst mis",   {31'd0, MisalignW},  32'd0);
    chk_eq("rst addr",  dmem_addr,           32'h0);
    chk_eq("rst be",    {28'd0, dmem_be},    32'd0);
    chk_eq("rst wdata", dmem_wdata,          32'h0);
    chk_eq("rst data",  LoadDataW,           32'h0);
    chk_eq("rst rd",    {27'd0, LoadRdW},    32'd0);
    step();
    reset = 1'b1;
    step();

    //     tag      rd    wr    size   uns   addr          wd            a3  w  rdata         fl    be       wdata         v     data
    do_op("lw",    1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h1234_5678, 5, 0, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0,        1'b1, 32'hDEADBEEF);
    do_op("lb",    1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0,         7, 0, 32'h80112233, 1'b0, 4'b1000, 32'h0,        1'b1, 32'hFFFFFF80);
    do_op("lbu",   1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0,         8, 1, 32'h80112233, 1'b0, 4'b1000, 32'h0,        1'b1, 32'h00000080);
    do_op("lh",    1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_1002, 32'h0,         9, 0, 32'h80112233, 1'b0, 4'b1100, 32'h0,        1'b1, 32'hFFFF8011);
    do_op("lhu",   1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_1002, 32'h0,        10, 0, 32'h80112233, 1'b0, 4'b1100, 32'h0,        1'b1, 32'h00008011);
    do_op("lb0",   1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1000, 32'h0,        11, 0, 32'h80112233, 1'b0, 4'b0001, 32'h0,        1'b1, 32'h00000033);
    do_op("lh0",   1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_1000, 32'h0,        12, 0, 32'h80119234, 1'b0, 4'b0011, 32'h0,        1'b1, 32'hFFFF9234);
    do_op("sh",    1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000ABCD, 13, 3, 32'h0,        1'b0, 4'b1100, 32'hABCDABCD, 1'b0, 32'h0);
    do_op("sb",    1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_2001, 32'h123456A5, 14, 1, 32'h0,        1'b0, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'h0);
    do_op("sw",    1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_2004, 32'hCAFEF00D, 15, 0, 32'h0,        1'b0, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0);
    do_op("lw x0", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0,         0, 0, 32'h0BADF00D, 1'b0, 4'b1111, 32'h0,        1'b1, 32'h0BADF00D);
    do_op("sz11",  1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_3004, 32'h0,         3, 0, 32'h01020304, 1'b0, 4'b1111, 32'h0,        1'b1, 32'h01020304);
    do_op("flush", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0,         6, 2, 32'h11112222, 1'b1, 4'b1111, 32'h0,        1'b0, 32'h0);
    do_op("post",  1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1008, 32'h0,         4, 0, 32'h33334444, 1'b0, 4'b1111, 32'h0,        1'b1, 32'h33334444);

    // Misaligned word load: one-cycle pulse, no request, no stall.
    MemReadW = 1'b1; MemSizeW = 2'b10; ALUResultW = 32'h0000_1001; A3_W = 5'd2;
    #4;
    chk_eq("mis pulse", {31'd0, MisalignW}, 32'd1);
    chk_eq("mis stall", {31'd0, StallW},    32'd0);
    step();
    MemReadW = 1'b0;
    #4;
    chk_eq("mis req",   {31'd0, dmem_req},  32'd0);
    chk_eq("mis clear", {31'd0, MisalignW}, 32'd0);
    step();

    // Flush in IDLE: nothing starts.
    MemReadW = 1'b1; MemSizeW = 2'b10; ALUResultW = 32'h0000_1000; FlushW = 1'b1;
    #4;
    chk_eq("fli stall", {31'd0, StallW}, 32'd0);
    step();
    MemReadW = 1'b0; FlushW = 1'b0;
    #4;
    chk_eq("fli req", {31'd0, dmem_req}, 32'd0);
    step();

    // Reset in the middle of BUSY drops the request.
    MemReadW = 1'b1; MemSizeW = 2'b10; ALUResultW = 32'h0000_4000; A3_W = 5'd9;
    step();
    #4;
    chk_eq("mid busy req", {31'd0, dmem_req}, 32'd1);
    reset = 1'b0;
    step();
    reset = 1'b1; MemReadW = 1'b0;
    #4;
    chk_eq("mid rst req",   {31'd0, dmem_req},   32'd0);
    chk_eq("mid rst stall", {31'd0, StallW},     32'd0);
    chk_eq("mid rst addr",  dmem_addr,           32'h0);
    chk_eq("mid rst valid", {31'd0, LoadValidW}, 32'd0);
    step();
    do_op("lw rst", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 9, 1, 32'h55667788, 1'b0, 4'b1111, 32'h0, 1'b1, 32'h55667788);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dp_wb_lsu.md
# dp_wb_lsu

Writeback-stage load/store unit that consumes the EX/WB pipeline register outputs and drives the external data-memory bus. It takes the registered ALU result as the address and the registered RD2 as store data, runs a request/acknowledge transaction, and raises StallW to freeze the W stage until the memory responds. It then returns aligned and extended load data with the destination register index for register-file writeback.

## Interface
- No parameters; the 32-bit datapath is fixed.
- clk  in  1  core clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low; sampled on rising clk
- MemReadW  in  1  W-stage instruction is a load
- MemWriteW  in  1  W-stage instruction is a store; never high together with MemReadW
- MemSizeW  in  2  access size: 00 byte, 01 half, 10 word; 11 is illegal and treated as word
- MemUnsignedW  in  1  zero-extend loads (LBU/LHU)
- FlushW  in  1  flush from the hazard unit
- A3_W  in  5  destination register of the W instruction
- ALUResultW  in  32  effective address
- RD2_W  in  32  store data, right-justified
- dmem_ack  in  1  memory completes the current request; dmem_rdata is valid in this cycle
- dmem_rdata  in  32  read data word
- dmem_req  out  1  request; held until dmem_ack
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  store data, replicated across byte lanes
- StallW  out  1  holds the W stage and upstream stages
- LoadValidW  out  1  single-cycle pulse: LoadDataW and LoadRdW are valid, and the register file writes
- LoadDataW  out  32  aligned, extended load result
- LoadRdW  out  5  destination register for LoadDataW
- MisalignW  out  1  single-cycle pulse: misaligned access, no bus activity

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, with MemReadW or MemWriteW high and FlushW low:
  - An aligned access (half: addr[0]=0; word: addr[1:0]=0) latches addr, be, wdata, we, size, unsigned flag and A3_W, then moves to BUSY. StallW is asserted combinationally in this cycle.
  - A misaligned access pulses MisalignW in the same cycle. There is no stall and no state change.
- IDLE with FlushW high: no request starts and no stall.
- BUSY:
  - dmem_req=1 with the latched fields; StallW=1.
  - On dmem_ack: capture dmem_rdata (loads only) and move to DONE.
- DONE:
  - StallW=0, so the W register advances at the end of this cycle.
  - A load pulses LoadValidW with LoadDataW and LoadRdW; a store produces no pulse.
  - Returns to IDLE unconditionally.
- Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
- Store data lanes: byte {4{b}}; half {2{h}}; word unchanged.
- Load extraction:
  - byte: the byte at lane addr[1:0]; half: the half at lane addr[1].
  - Sign-extend, or zero-extend when the unsigned flag is set.
- A3_W=0 on a load: the transaction still runs, and LoadValidW pulses with LoadRdW=0. Writing x0 is dropped by the register file.
- FlushW while in BUSY or DONE: the bus transaction completes, and a cancel flag suppresses LoadValidW in DONE.

## Timing
- Reset (reset=0 at an edge), including mid-transaction:
  - state goes to IDLE and the cancel flag clears.
  - dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, LoadValidW, LoadDataW, LoadRdW and MisalignW all go to 0.
  - The memory must tolerate a dropped request.
- Zero-wait memory (ack in the first BUSY cycle) gives:
  - cycle 0 IDLE (stall)
  - cycle 1 BUSY (req, ack)
  - cycle 2 DONE
  - The W stage is occupied for 3 cycles.
- Each additional wait cycle adds one BUSY cycle. There is no timeout.
- dmem_req deasserts in the cycle after dmem_ack. A new request cannot issue earlier than the IDLE cycle that follows DONE, plus one.
- Back-to-back memory ops: the second op is evaluated in the IDLE cycle after DONE, so ops are spaced 3 cycles minimum.
- dmem_ack is ignored outside BUSY.

## Structure
- lsu_pkg holds:
  - the FSM state enum (lsu_state_t)
  - the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - the functions for byte-enable generation and store-lane replication
- Sub-module dp_load_align is purely combinational: it takes rdata, addr[1:0], size and unsigned, and produces the extended result.
- The top level holds the FSM, the latches and the cancel flag.

## Test plan
- LW at 0x1000 with RD2=x, ack in the first BUSY cycle:
  - dmem_addr=0x1000, be=1111, we=0.
  - StallW high for exactly 2 cycles.
  - With dmem_rdata=0xDEADBEEF, LoadValidW pulses with LoadDataW=0xDEADBEEF and LoadRdW=A3_W.
- LB at 0x1003 with rdata=0x80112233:
  - dmem_be=1000, LoadDataW=0xFFFFFF80.
  - LBU gives 0x00000080. LH at 0x1002 gives 0xFFFF8011.
- SH at 0x2002 with RD2=0x0000ABCD and ack delayed 3 cycles:
  - be=1100, wdata=0xABCDABCD, req held for 4 cycles.
  - StallW released in DONE; no LoadValidW.
- LW at 0x1001: MisalignW pulses for 1 cycle, dmem_req stays 0, StallW stays 0.
- FlushW asserted during BUSY of a LW:
  - req is held until ack.
  - LoadValidW stays 0 in DONE.
  - The FSM returns to IDLE.
- reset=0 driven mid-BUSY:
  - The next cycle has dmem_req=0, StallW=0 and state IDLE.
  - A LW issued after reset releases completes normally.
